// File: rtl/pixel_packer.sv
// pixel_packer
// Packs 24-bit RGB pixels, four at a time, into three 32-bit AXI4-Stream
// words for the video DMA. tuser marks the first word of a frame and
// tlast marks the last word of each line.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   r, g, b                pixel colour channels; pixel word is {r, g, b}
//   in_valid               pixel present
//   in_stream_ready        pixel accepted when in_valid && in_stream_ready
//   restart                synchronous pulse: realign to pixel (0,0)
//   out_stream_tdata       packed pixel data
//   out_stream_tkeep       always 4'hF
//   out_stream_tuser       start of frame
//   out_stream_tlast       end of line
//   out_stream_tvalid      output word valid
//   out_stream_tready      downstream ready
module pixel_packer #(
    parameter int X_SIZE = 640,
    parameter int Y_SIZE = 480
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        in_valid,
    output logic        in_stream_ready,
    input  logic        restart,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tuser,
    output logic        out_stream_tlast,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready
);

    localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
    localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    logic [1:0]    phase_q, phase_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [23:0]   res_q, res_d;
    logic          sof_q, sof_d;     // current group started at pixel (0,0)
    logic [31:0]   tdata_q, tdata_d;
    logic          tuser_q, tuser_d;
    logic          tlast_q, tlast_d;
    logic          tvalid_q, tvalid_d;

    logic [23:0]   pix;
    logic          accept;
    logic [31:0]   word;

    assign pix = {r, g, b};

    // Phase-0 pixels emit nothing, so they may be taken even while the
    // output slot is stalled.
    assign in_stream_ready = !restart && (phase_q == 2'd0 || !tvalid_q || out_stream_tready);
    assign accept          = in_valid && in_stream_ready;

    always_comb begin
        word = 32'h0;
        case (phase_q)
            2'd1:    word = {pix[7:0], res_q[23:0]};
            2'd2:    word = {pix[15:0], res_q[15:0]};
            2'd3:    word = {pix[23:0], res_q[7:0]};
            default: word = 32'h0;
        endcase
    end

    always_comb begin
        phase_d  = phase_q;
        x_d      = x_q;
        y_d      = y_q;
        res_d    = res_q;
        sof_d    = sof_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;

        if (restart) begin
            phase_d = 2'd0;
            x_d     = '0;
            y_d     = '0;
            res_d   = 24'h0;
            sof_d   = 1'b0;
        end else if (accept) begin
            phase_d = phase_q + 2'd1;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
            case (phase_q)
                2'd0: begin
                    res_d = pix;
                    sof_d = (x_q == '0) && (y_q == '0);
                end
                2'd1:    res_d = {8'h00, pix[23:8]};
                2'd2:    res_d = {16'h0000, pix[23:16]};
                default: res_d = res_q;
            endcase
        end

        // restart forces accept low, so a pending word is never dropped here.
        if (accept && phase_q != 2'd0) begin
            tvalid_d = 1'b1;
            tdata_d  = word;
            tuser_d  = (phase_q == 2'd1) && sof_q;
            tlast_d  = (phase_q == 2'd3) && (x_q == X_LAST);
        end else if (out_stream_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q  <= 2'd0;
            x_q      <= '0;
            y_q      <= '0;
            res_q    <= 24'h0;
            sof_q    <= 1'b0;
            tdata_q  <= 32'h0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            x_q      <= x_d;
            y_q      <= y_d;
            res_q    <= res_d;
            sof_q    <= sof_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign out_stream_tdata  = tdata_q;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tuser  = tuser_q;
    assign out_stream_tlast  = tlast_q;
    assign out_stream_tvalid = tvalid_q;

endmodule

// File: doc/pixel_packer.md
# pixel_packer

Final stage of the ray-tracer output path. It sits directly downstream of the pixel buffer and accepts one 24-bit RGB pixel per handshake. It packs every four pixels into three 32-bit AXI4-Stream words for the video DMA, marking start-of-frame on `tuser` and end-of-line on `tlast`. It is the sole source of the `in_stream_ready` back-pressure seen by the pixel buffer.

## Interface
- `X_SIZE`, default 640: pixels per line; must be a multiple of 4.
- `Y_SIZE`, default 480: lines per frame.
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `r`, `g`, `b`  in  8 each  pixel colour channels.
- `in_valid`  in  1  pixel present.
- `in_stream_ready`  out  1  pixel accepted when `in_valid && in_stream_ready`.
- `restart`  in  1  synchronous pulse; aborts the current frame and realigns to pixel (0,0).
- `out_stream_tdata`  out  32  packed pixel data.
- `out_stream_tkeep`  out  4  constant 4'hF.
- `out_stream_tuser`  out  1  start of frame.
- `out_stream_tlast`  out  1  end of line.
- `out_stream_tvalid`  out  1  output word valid.
- `out_stream_tready`  in  1  downstream ready.

## Operation
- Pixel word P = {r, g, b}, 24 bits; `b` sits in bits 7:0.
- A 2-bit `phase` counts pixels within the current 4-pixel group. A residual register `res` holds up to 24 bits.
- On an accepted pixel, behaviour depends on `phase`:
  - phase 0: `res` ← P. No word is emitted.
  - phase 1: emit W0 = {P[7:0], res[23:0]}. `res` ← P[23:8].
  - phase 2: emit W1 = {P[15:0], res[15:0]}. `res` ← P[23:16].
  - phase 3: emit W2 = {P[23:0], res[7:0]}.
  - `phase` then increments, wrapping 3→0.
- Counter `x` runs 0..X_SIZE-1 and counter `y` runs 0..Y_SIZE-1. Both advance per accepted pixel.
  - `x` wraps to 0 after X_SIZE-1, and `y` increments on that wrap.
  - `y` wraps to 0 after Y_SIZE-1.
- `tuser` = 1 on W0 when its phase-0 pixel was at x=0, y=0.
- `tlast` = 1 on W2 when its phase-3 pixel has x = X_SIZE-1.
- One frame = X_SIZE·Y_SIZE·3/4 words. There is exactly one `tuser` per frame and Y_SIZE `tlast`s.
- Output is a single registered slot.
  - `in_stream_ready` = !`restart` && (`phase`==0 || !`tvalid` || `tready`). This is combinational from `tready`, `tvalid` and `phase`.
  - Phase-0 pixels are accepted even while the output is stalled, because they emit nothing.
- `restart`:
  - Clears `phase`, `x`, `y` and `res`.
  - Discards any partial group.
  - Does not drop a pending output word: `tvalid` stays high until that word is handshaken.
  - A pixel presented in the `restart` cycle is not accepted.

## Timing
- Reset values:
  - `tvalid`, `tuser`, `tlast` = 0.
  - `tdata` = 0.
  - `tkeep` = 4'hF.
  - `phase`, `x`, `y`, `res` = 0.
  - `in_stream_ready` = 1.
- Latency: the word appears with `tvalid` = 1 in the cycle after the completing pixel (phase 1, 2 or 3) is accepted.
- While `tvalid && !tready`, `tdata`, `tuser` and `tlast` hold stable.
- If `tready` = 1 and a new word-producing pixel is accepted in the same cycle, the slot is overwritten. `tvalid` stays 1, giving back-to-back words with no bubble.
- If `tready` = 1 and no word-producing pixel is accepted, `tvalid` falls to 0 next cycle.
- Sustained throughput: 1 pixel/cycle with `tready` held high.
- Asynchronous reset mid-frame drops all state immediately, including any pending word. After release the first pixel is treated as (0,0).

## Test plan
- X_SIZE=8, Y_SIZE=2, `tready`=1. Pixels 0x112233, 0x445566, 0x778899, 0xAABBCC → words 0x66112233 (`tuser`=1), 0x88994455, 0xAABBCC77 (`tlast`=0). Each word appears one cycle after its pixel.
- Full frame of 16 incrementing pixels → 12 words, `tuser` only on word 0, `tlast` on words 5 and 11. The next frame's word 0 again carries `tuser`=1.
- `tready`=0 after W0 is emitted:
  - Next pixel (phase 2) sees `in_stream_ready`=0 and W0 holds stable.
  - Raising `tready` completes the handshake. W1 follows and no data is lost or duplicated.
- Back-pressure with a phase-0 pixel: while W2 is pending and `tready`=0, the next pixel is still accepted (`in_stream_ready`=1). The following pixel is stalled.
- `restart` asserted after 2 pixels of a group: no W1 is produced. The next 4 pixels produce W0 with `tuser`=1. A pixel offered during the `restart` cycle is not accepted.
- Assert `aresetn`=0 while `tvalid`=1 → `tvalid` drops immediately. After release, `in_stream_ready`=1 and the first group emits with `tuser`=1.
